clock_time_ctrl: RTL and testbench

- Sequencing controller for the seconds, minutes and hours 6-bit parallel-load counters of the digital clock.
- Converts a 1 Hz tick into en/clr pulses with carry between the three counters.
- Runs the user time-set mode (mode/inc buttons) and the external preset-load request.
- Counters are never driven directly by the tick or the buttons; all of their control inputs come from this block.

---
 rtl/clock_time_ctrl.sv | 146 ++++++++++++++
 tb/tb_clock_time_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// Sequencing controller for the sec/min/hr counters of a digital clock.
// Turns tick, buttons and load/clear requests into registered one-cycle counter controls.
module clock_time_ctrl #(
  parameter int W       = 6,
  parameter int MAX_SEC = 59,
  parameter int MAX_MIN = 59,
  parameter int MAX_HR  = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         mode_btn,
  input  logic         inc_btn,
  input  logic         load_req,
  input  logic         clr_req,
  input  logic [W-1:0] sec,
  input  logic [W-1:0] min,
  input  logic [W-1:0] hr,
  output logic         en_sec,
  output logic         clr_sec,
  output logic         ld_sec,
  output logic         en_min,
  output logic         clr_min,
  output logic         ld_min,
  output logic         en_hr,
  output logic         clr_hr,
  output logic         ld_hr,
  output logic         sel_hr,
  output logic         sel_min
);

  localparam logic [W-1:0] SEC_T = W'(MAX_SEC);
  localparam logic [W-1:0] MIN_T = W'(MAX_MIN);
  localparam logic [W-1:0] HR_T  = W'(MAX_HR);

  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} state_t;

  typedef struct packed {
    logic en_s, clr_s, ld_s;
    logic en_m, clr_m, ld_m;
    logic en_h, clr_h, ld_h;
  } ctrl_t;

  state_t state, state_nxt;
  ctrl_t  pulse, pulse_nxt;

  // Input sample stage: events sampled at one edge act at the next.
  logic tick_s, load_s, clr_s, mode_s, inc_s, mode_q, inc_q;
  logic mode_ev, inc_ev, busy;

  assign mode_ev = mode_s & ~mode_q;
  assign inc_ev  = inc_s  & ~inc_q;
  // While a pulse is out, the counters still hold stale values.
  assign busy    = |pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_s <= 1'b0;
      load_s <= 1'b0;
      clr_s  <= 1'b0;
      mode_s <= 1'b0;
      inc_s  <= 1'b0;
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      tick_s <= tick;
      load_s <= load_req;
      clr_s  <= clr_req;
      mode_s <= mode_btn;
      inc_s  <= inc_btn;
      mode_q <= mode_s;
      inc_q  <= inc_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      pulse   <= '0;
      sel_hr  <= 1'b0;
      sel_min <= 1'b0;
    end else begin
      state   <= state_nxt;
      pulse   <= pulse_nxt;
      sel_hr  <= (state_nxt == SET_HR);
      sel_min <= (state_nxt == SET_MIN);
    end
  end

  always_comb begin
    state_nxt = state;
    pulse_nxt = '0;
    if (clr_s) begin
      pulse_nxt.clr_s = 1'b1;
      pulse_nxt.clr_m = 1'b1;
      pulse_nxt.clr_h = 1'b1;
      state_nxt       = RUN;
    end else if (load_s) begin
      pulse_nxt.ld_s = 1'b1;
      pulse_nxt.ld_m = 1'b1;
      pulse_nxt.ld_h = 1'b1;
      state_nxt      = RUN;
    end else if (!busy) begin
      if (mode_ev) begin
        case (state)
          RUN: begin
            state_nxt       = SET_HR;
            pulse_nxt.clr_s = 1'b1;
          end
          SET_HR:  state_nxt = SET_MIN;
          default: state_nxt = RUN;
        endcase
      end else if (inc_ev && state == SET_HR) begin
        if (hr >= HR_T) pulse_nxt.clr_h = 1'b1;
        else            pulse_nxt.en_h  = 1'b1;
      end else if (inc_ev && state == SET_MIN) begin
        if (min >= MIN_T) pulse_nxt.clr_m = 1'b1;
        else              pulse_nxt.en_m  = 1'b1;
      end else if (tick_s && state == RUN) begin
        if (sec >= SEC_T) begin
          pulse_nxt.clr_s = 1'b1;
          if (min >= MIN_T) begin
            pulse_nxt.clr_m = 1'b1;
            if (hr >= HR_T) pulse_nxt.clr_h = 1'b1;
            else            pulse_nxt.en_h  = 1'b1;
          end else begin
            pulse_nxt.en_m = 1'b1;
          end
        end else begin
          pulse_nxt.en_s = 1'b1;
        end
      end
    end
  end

  assign en_sec  = pulse.en_s;
  assign clr_sec = pulse.clr_s;
  assign ld_sec  = pulse.ld_s;
  assign en_min  = pulse.en_m;
  assign clr_min = pulse.clr_m;
  assign ld_min  = pulse.ld_m;
  assign en_hr   = pulse.en_h;
  assign clr_hr  = pulse.clr_h;
  assign ld_hr   = pulse.ld_h;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: directed scenarios plus random traffic, every cycle
// compared against an event-level model of the clock-setting rules.
module tb_clock_time_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 0, mode_btn = 0, inc_btn = 0, load_req = 0, clr_req = 0;
  logic [5:0] sec = 0, min = 0, hr = 0;
  logic en_sec, clr_sec, ld_sec, en_min, clr_min, ld_min, en_hr, clr_hr, ld_hr;
  logic sel_hr, sel_min;

  always #5 clk = ~clk;

  clock_time_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .load_req(load_req), .clr_req(clr_req), .sec(sec), .min(min), .hr(hr),
    .en_sec(en_sec), .clr_sec(clr_sec), .ld_sec(ld_sec),
    .en_min(en_min), .clr_min(clr_min), .ld_min(ld_min),
    .en_hr(en_hr), .clr_hr(clr_hr), .ld_hr(ld_hr),
    .sel_hr(sel_hr), .sel_min(sel_min)
  );

  // {en_sec,clr_sec,ld_sec,en_min,clr_min,ld_min,en_hr,clr_hr,ld_hr,sel_hr,sel_min}
  logic [10:0] out_vec;
  assign out_vec = {en_sec, clr_sec, ld_sec, en_min, clr_min, ld_min,
                    en_hr, clr_hr, ld_hr, sel_hr, sel_min};

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b expected=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0=run, 1=set hours, 2=set minutes; events from one and two steps back.
  int mdl_mode = 0;
  logic [10:0] exp_cur = '0;
  logic p_tick = 0, p_load = 0, p_clr = 0, p_mode = 0, pp_mode = 0, p_inc = 0, pp_inc = 0;

  function automatic logic [10:0] predict(input logic [5:0] s, input logic [5:0] m,
                                          input logic [5:0] h);
    logic [10:0] r;
    int nm;
    r  = '0;
    nm = mdl_mode;
    if (p_clr) begin
      r[9] = 1; r[6] = 1; r[3] = 1; nm = 0;
    end else if (p_load) begin
      r[8] = 1; r[5] = 1; r[2] = 1; nm = 0;
    end else if (exp_cur[10:2] == 0) begin
      if (p_mode && !pp_mode) begin
        nm = (mdl_mode + 1) % 3;
        if (mdl_mode == 0) r[9] = 1;
      end else if (p_inc && !pp_inc && mdl_mode == 1) begin
        if (h >= 23) r[3] = 1; else r[4] = 1;
      end else if (p_inc && !pp_inc && mdl_mode == 2) begin
        if (m >= 59) r[6] = 1; else r[7] = 1;
      end else if (p_tick && mdl_mode == 0) begin
        if (s < 59) r[10] = 1;
        else begin
          r[9] = 1;
          if (m < 59) r[7] = 1;
          else begin
            r[6] = 1;
            if (h < 23) r[4] = 1; else r[3] = 1;
          end
        end
      end
    end
    r[1] = (nm == 1);
    r[0] = (nm == 2);
    mdl_mode = nm;
    return r;
  endfunction

  task automatic step(input logic t, input logic md, input logic ic, input logic ld,
                      input logic cl, input logic [5:0] s, input logic [5:0] m,
                      input logic [5:0] h, input string tag);
    logic [10:0] nxt;
    @(negedge clk);
    chk(tag, out_vec, exp_cur);
    nxt = predict(s, m, h);
    tick = t; mode_btn = md; inc_btn = ic; load_req = ld; clr_req = cl;
    sec = s; min = m; hr = h;
    pp_mode = p_mode; p_mode = md;
    pp_inc = p_inc; p_inc = ic;
    p_tick = t; p_load = ld; p_clr = cl;
    exp_cur = nxt;
  endtask

  task automatic idle(input int n, input logic [5:0] s, input logic [5:0] m,
                      input logic [5:0] h, input string tag);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, s, m, h, tag);
  endtask

  task automatic model_reset();
    mdl_mode = 0; exp_cur = '0;
    p_tick = 0; p_load = 0; p_clr = 0; p_mode = 0; pp_mode = 0; p_inc = 0; pp_inc = 0;
  endtask

  function automatic logic [5:0] rv(input int mx);
    case ($urandom % 4)
      0: return 6'(mx);
      1: return 6'($urandom % (mx + 1));
      2: return 6'(mx + 1 + ($urandom % (63 - mx)));
      default: return 6'($urandom % 64);
    endcase
  endfunction

  initial begin
    logic rm, ri;
    repeat (3) @(negedge clk);
    chk("reset_state", out_vec, 11'b0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Plain second increment
    step(1, 0, 0, 0, 0, 10, 0, 0, "tick_sec10");
    idle(4, 10, 0, 0, "tick_sec10");

    // Full rollover and hour carry
    step(1, 0, 0, 0, 0, 59, 59, 23, "roll_23");
    idle(4, 59, 59, 23, "roll_23");
    step(1, 0, 0, 0, 0, 59, 59, 5, "roll_5");
    idle(4, 59, 59, 5, "roll_5");

    // Held mode button: single edge into SET_HR
    for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0, 30, 20, 10, "mode_hold");
    idle(3, 30, 20, 10, "mode_rel");
    step(0, 1, 0, 0, 0, 30, 20, 10, "mode2");
    idle(3, 30, 20, 10, "set_min");

    // SET_MIN: inc at terminal clears minutes only; ticks ignored
    step(0, 0, 1, 0, 0, 30, 59, 23, "inc_min59");
    idle(3, 30, 59, 23, "inc_min59");
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 30, 10, 4, "tick_setmin");
      idle(3, 30, 10, 4, "tick_setmin");
    end
    step(0, 1, 0, 0, 0, 0, 0, 0, "mode3");
    idle(3, 0, 0, 0, "back_run");

    // SET_HR: load beats inc and tick
    step(0, 1, 0, 0, 0, 5, 5, 5, "to_sethr");
    idle(3, 5, 5, 5, "to_sethr");
    step(1, 0, 1, 1, 0, 5, 5, 5, "load_prio");
    idle(4, 5, 5, 5, "load_prio");
    step(0, 1, 0, 0, 0, 5, 5, 5, "to_sethr2");
    idle(3, 5, 5, 5, "to_sethr2");
    step(1, 0, 1, 1, 1, 5, 5, 5, "clr_prio");
    idle(4, 5, 5, 5, "clr_prio");

    // Out-of-range counts treated as terminal
    step(1, 0, 0, 0, 0, 62, 60, 30, "oor");
    idle(4, 62, 60, 30, "oor");

    // Reset while en_min is high
    step(1, 0, 0, 0, 0, 59, 10, 3, "rst_mid");
    idle(2, 59, 10, 3, "rst_mid");
    #2 reset = 1'b0;
    #1 chk("rst_async", out_vec, 11'b0);
    repeat (2) @(negedge clk);
    chk("rst_hold", out_vec, 11'b0);
    reset = 1'b1;
    model_reset();
    idle(4, 59, 10, 3, "post_rst");

    // Random traffic
    rm = 0; ri = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 8 == 0) rm = ~rm;
      if ($urandom % 4 == 0) ri = ~ri;
      step(($urandom % 4) == 0, rm, ri, ($urandom % 40) == 0, ($urandom % 60) == 0,
           rv(59), rv(59), rv(23), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
